// File: rtl/regfile_wb_if.sv
// Write-back request channel from the result sources into the write-back queue.
// A request transfers on a rising clk edge where req_valid && req_ready; the master holds rd/data stable while valid is high and not yet accepted.
interface regfile_wb_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rd;
    logic [31:0] req_data;

    modport master (output req_valid, output req_rd, output req_data, input req_ready);
    modport slave  (input req_valid, input req_rd, input req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue owning the register file write port; retires one entry per cycle
// and reports pending writes (youngest match) for decode-stage forwarding.
module regfile_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    regfile_wb_if.slave                req,
    input  logic                       wb_stall,
    output logic                       rf_we,
    output logic [4:0]                 rf_rd,
    output logic [31:0]                rf_data,
    input  logic [4:0]                 Rs1,
    input  logic [4:0]                 Rs2,
    output logic                       rs1_hit,
    output logic                       rs2_hit,
    output logic [31:0]                rs1_fwd,
    output logic [31:0]                rs2_fwd,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    rd_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;

    logic full;
    logic empty;
    logic push_ok;
    logic enq;
    logic pop;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

    // Ready looks only at the registered count, so a full queue refuses even while popping.
    assign req.req_ready = !full;
    assign push_ok       = req.req_valid && !full;
    assign enq           = push_ok && (req.req_rd != 5'd0);
    assign pop           = !empty && !wb_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            case ({enq, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage needs no reset: occupancy is tracked entirely by head and cnt.
    always_ff @(posedge clk) begin
        if (enq) begin
            rd_mem[tail]   <= req.req_rd;
            data_mem[tail] <= req.req_data;
        end
    end

    assign rf_we   = pop;
    assign rf_rd   = pop ? rd_mem[head]   : 5'd0;
    assign rf_data = pop ? data_mem[head] : 32'd0;

    // Walk oldest to youngest so the last match found is the youngest one.
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        rs1_fwd = 32'd0;
        rs2_fwd = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (CW'(k) < cnt) begin
                if ((Rs1 != 5'd0) && (rd_mem[idx] == Rs1)) begin
                    rs1_hit = 1'b1;
                    rs1_fwd = data_mem[idx];
                end
                if ((Rs2 != 5'd0) && (rd_mem[idx] == Rs2)) begin
                    rs2_hit = 1'b1;
                    rs2_fwd = data_mem[idx];
                end
            end
        end
    end

    assign count = cnt;
    assign idle  = empty;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: table of cycle vectors, hand sequences for stall/fill, wrap and
// asynchronous reset, and a scoreboard checking every register-file write in order.
module tb_regfile_wb_queue;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        wb_stall;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic [4:0]  rs1, rs2;
    logic        rs1_hit, rs2_hit;
    logic [31:0] rs1_fwd, rs2_fwd;
    logic [2:0]  count;
    logic        idle;

    regfile_wb_if bus ();

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (bus),
        .wb_stall (wb_stall),
        .rf_we    (rf_we),
        .rf_rd    (rf_rd),
        .rf_data  (rf_data),
        .Rs1      (rs1),
        .Rs2      (rs2),
        .rs1_hit  (rs1_hit),
        .rs2_hit  (rs2_hit),
        .rs1_fwd  (rs1_fwd),
        .rs2_fwd  (rs2_fwd),
        .count    (count),
        .idle     (idle)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [36:0] exp_q[$];

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (rf_we) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected_write: got rd=%0d data=0x%0h expected no write", rf_rd, rf_data);
                end else begin
                    check("sb_write", {27'd0, rf_rd, rf_data}, {27'd0, exp_q.pop_front()});
                end
            end
            if (bus.req_valid && bus.req_ready && (bus.req_rd != 5'd0))
                exp_q.push_back({bus.req_rd, bus.req_data});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] data, input logic st);
        bus.req_valid = v;
        bus.req_rd    = rd;
        bus.req_data  = data;
        wb_stall      = st;
    endtask

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        stall;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_ready;
        logic [2:0]  e_count;
        logic        e_we;
        logic [4:0]  e_rf_rd;
        logic [31:0] e_rf_data;
        logic        e_hit1;
        logic [31:0] e_fwd1;
        logic        e_hit2;
        logic [31:0] e_fwd2;
        logic        e_idle;
    } vec_t;

    vec_t vecs[9];

    initial begin
        // inputs for the cycle | outputs expected during that cycle (before its edge)
        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  1'b1};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd0, 1'b1, 3'd1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,  1'b0};
        vecs[2] = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 5'd0, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  1'b1};
        vecs[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  1'b1};
        vecs[4] = '{1'b1, 5'd7, 32'h11,       1'b1, 5'd0, 5'd7, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  1'b1};
        vecs[5] = '{1'b1, 5'd7, 32'h22,       1'b1, 5'd0, 5'd7, 1'b1, 3'd1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h11, 1'b0};
        vecs[6] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 1'b1, 3'd2, 1'b1, 5'd7, 32'h11,       1'b0, 32'h0,        1'b1, 32'h22, 1'b0};
        vecs[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 1'b1, 3'd1, 1'b1, 5'd7, 32'h22,       1'b0, 32'h0,        1'b1, 32'h22, 1'b0};
        vecs[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  1'b1};

        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        rs1 = 5'd0;
        rs2 = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", bus.req_ready, 1);
        check("reset_idle", idle, 1);
        check("reset_rf_we", rf_we, 0);
        rst = 1'b0;
        step();

        // ---- table vectors: single write, x0 discard, youngest-match forwarding ----
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].valid, vecs[i].rd, vecs[i].data, vecs[i].stall);
            rs1 = vecs[i].rs1;
            rs2 = vecs[i].rs2;
            #3;
            check($sformatf("v%0d_ready", i),   bus.req_ready, vecs[i].e_ready);
            check($sformatf("v%0d_count", i),   count,         vecs[i].e_count);
            check($sformatf("v%0d_rf_we", i),   rf_we,         vecs[i].e_we);
            check($sformatf("v%0d_rf_rd", i),   rf_rd,         vecs[i].e_rf_rd);
            check($sformatf("v%0d_rf_data", i), rf_data,       vecs[i].e_rf_data);
            check($sformatf("v%0d_rs1_hit", i), rs1_hit,       vecs[i].e_hit1);
            check($sformatf("v%0d_rs1_fwd", i), rs1_fwd,       vecs[i].e_fwd1);
            check($sformatf("v%0d_rs2_hit", i), rs2_hit,       vecs[i].e_hit2);
            check($sformatf("v%0d_rs2_fwd", i), rs2_fwd,       vecs[i].e_fwd2);
            check($sformatf("v%0d_idle", i),    idle,          vecs[i].e_idle);
            step();
        end

        // ---- fill under stall, fifth request held, in-order drain ----
        rs1 = 5'd3;
        rs2 = 5'd0;
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, 5'(i), 32'(100 + i), 1'b1);
            #3;
            check("fill_count", count, i - 1);
            step();
        end
        drive(1'b1, 5'd9, 32'h99, 1'b1);
        #3;
        check("full_count", count, 4);
        check("full_ready", bus.req_ready, 0);
        check("full_no_we", rf_we, 0);
        check("full_rs1_fwd", rs1_fwd, 103);
        step();
        #3;
        check("held_count", count, 4);
        step();
        wb_stall = 1'b0;
        #3;
        check("drain0_rd", rf_rd, 1);
        check("drain0_ready", bus.req_ready, 0);
        step();
        #3;
        check("drain1_rd", rf_rd, 2);
        check("drain1_ready", bus.req_ready, 1);
        check("drain1_count", count, 3);
        step();
        bus.req_valid = 1'b0;
        #3;
        check("drain2_rd", rf_rd, 3);
        check("drain2_count", count, 3);
        step();
        #3;
        check("drain3_rd", rf_rd, 4);
        step();
        #3;
        check("drain4_rd", rf_rd, 9);
        check("drain4_data", rf_data, 32'h99);
        step();
        #3;
        check("drain_idle", idle, 1);
        step();

        // ---- pointer wrap: back-to-back stream without stall ----
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 5'(i + 1), 32'(i), 1'b0);
            #3;
            check("wrap_count_le1", count <= 3'd1, 1);
            if (i > 0) begin
                check("wrap_we", rf_we, 1);
                check("wrap_rd", rf_rd, i);
            end else begin
                check("wrap_first_no_we", rf_we, 0);
            end
            step();
        end
        bus.req_valid = 1'b0;
        #3;
        check("wrap_last_rd", rf_rd, 10);
        check("wrap_last_data", rf_data, 9);
        step();
        #3;
        check("wrap_idle", idle, 1);
        step();

        // ---- asynchronous reset with three entries queued under stall ----
        rs1 = 5'd11;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(11 + i), 32'($urandom_range(1, 32'h7fff_ffff)), 1'b1);
            step();
        end
        bus.req_valid = 1'b0;
        #1;
        check("pre_rst_count", count, 3);
        check("pre_rst_hit", rs1_hit, 1);
        rst = 1'b1;
        #1;
        check("rst_rf_we", rf_we, 0);
        check("rst_count", count, 0);
        check("rst_idle", idle, 1);
        check("rst_ready", bus.req_ready, 1);
        check("rst_rs1_hit", rs1_hit, 0);
        check("rst_rs1_fwd", rs1_fwd, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        wb_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            #2;
            check("post_rst_no_we", rf_we, 0);
            check("post_rst_idle", idle, 1);
        end
        check("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
